// File: rtl/touch_key_filter_pkg.sv
// Shared helpers for key-conditioning stages.
package touch_key_filter_pkg;

  // Bit width able to hold 0 .. max_val-1, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 2) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/touch_key_filter_sync_2ff.sv
// Two-flop synchronizer for a raw key level; resets to the released level (1).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/touch_key_filter.sv
// Touch key debounce with press/release pulses, long-press pulse and held level.
module touch_key_filter
  import touch_key_filter_pkg::*;
#(
  parameter int DEB_MAX  = 1_000_000,
  parameter int LONG_MAX = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic touch_key,
  output logic key_flag,
  output logic key_release,
  output logic long_flag,
  output logic key_state
);

  localparam int DEB_W  = cnt_width(DEB_MAX);
  localparam int LONG_W = cnt_width(LONG_MAX);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_MAX - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX - 1);
  localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_MAX - 2);

  typedef enum logic [1:0] {IDLE, PRESS_FILT, DOWN, REL_FILT} state_t;

  logic              key_s;
  state_t            state_reg, state_next;
  logic [DEB_W-1:0]  deb_reg, deb_next;
  logic [LONG_W-1:0] long_reg, long_next;
  logic              key_flag_reg, key_flag_next;
  logic              key_release_reg, key_release_next;
  logic              long_flag_reg, long_flag_next;
  logic              key_state_reg, key_state_next;

  sync_2ff u_sync (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .d    (touch_key),
    .q    (key_s)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg       <= IDLE;
      deb_reg         <= '0;
      long_reg        <= '0;
      key_flag_reg    <= 1'b0;
      key_release_reg <= 1'b0;
      long_flag_reg   <= 1'b0;
      key_state_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      deb_reg         <= deb_next;
      long_reg        <= long_next;
      key_flag_reg    <= key_flag_next;
      key_release_reg <= key_release_next;
      long_flag_reg   <= long_flag_next;
      key_state_reg   <= key_state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    deb_next         = deb_reg;
    long_next        = long_reg;
    key_flag_next    = 1'b0;
    key_release_next = 1'b0;
    long_flag_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!key_s) begin
          state_next = PRESS_FILT;
          deb_next   = '0;
        end
      end
      PRESS_FILT: begin
        if (key_s) begin
          state_next = IDLE;
        end else if (deb_reg == DEB_LAST) begin
          state_next    = DOWN;
          key_flag_next = 1'b1;
          long_next     = '0;
        end else begin
          deb_next = deb_reg + 1'b1;
        end
      end
      DOWN, REL_FILT: begin
        // Hold time keeps running through release filtering; saturation
        // makes the long pulse a once-per-press event.
        if (long_reg != LONG_LAST) begin
          long_next = long_reg + 1'b1;
        end
        if (state_reg == DOWN) begin
          if (key_s) begin
            state_next = REL_FILT;
            deb_next   = '0;
          end
        end else if (!key_s) begin
          state_next = DOWN;
        end else if (deb_reg == DEB_LAST) begin
          state_next       = IDLE;
          key_release_next = 1'b1;
        end else begin
          deb_next = deb_reg + 1'b1;
        end
        // A confirmed release ends the press, so it wins a same-cycle long event.
        long_flag_next = (long_reg == LONG_PRE) && !key_release_next;
      end
      default: state_next = IDLE;
    endcase
    key_state_next = (state_next == DOWN) || (state_next == REL_FILT);
  end

  assign key_flag    = key_flag_reg;
  assign key_release = key_release_reg;
  assign long_flag   = long_flag_reg;
  assign key_state   = key_state_reg;

endmodule

// File: tb/tb_touch_key_filter.sv
// Randomized scoreboard bench for touch_key_filter against a run-length reference model.
module tb_touch_key_filter;

  localparam int DEB_MAX  = 5;
  localparam int LONG_MAX = 20;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic touch_key = 1'b1;
  logic key_flag, key_release, long_flag, key_state;

  touch_key_filter #(.DEB_MAX(DEB_MAX), .LONG_MAX(LONG_MAX)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .touch_key  (touch_key),
    .key_flag   (key_flag),
    .key_release(key_release),
    .long_flag  (long_flag),
    .key_state  (key_state)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    int         cyc;
    logic [2:0] ev;   // {key_flag, key_release, long_flag}
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_flag = 0, n_rel = 0, n_long = 0;

  // Reference model: the debounced level flips once the synchronized input
  // has disagreed with it for DEB_MAX+1 consecutive samples.
  logic level = 1'b0;
  logic s1 = 1'b1, s2 = 1'b1;
  int   run  = 0;
  int   held = 0;

  task automatic push_ev(input logic [2:0] ev);
    exp_t e;
    e.cyc = cyc;
    e.ev  = ev;
    exp_q.push_back(e);
  endtask

  initial begin
    logic ks;
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        level = 1'b0; run = 0; held = 0; s1 = 1'b1; s2 = 1'b1;
        exp_q.delete();
      end else begin
        cyc++;
        ks = s2;
        s2 = s1;
        s1 = touch_key;
        if (!level) begin
          run = (ks == 1'b0) ? run + 1 : 0;
          if (run == DEB_MAX + 1) begin
            level = 1'b1; run = 0; held = 0;
            push_ev(3'b100);
          end
        end else begin
          if (held < LONG_MAX) held++;
          run = (ks == 1'b1) ? run + 1 : 0;
          if (run == DEB_MAX + 1) begin
            level = 1'b0; run = 0;
            push_ev(3'b010);
          end else if (held == LONG_MAX - 1) begin
            push_ev(3'b001);
          end
        end
      end
    end
  end

  // Monitor: compares every presented pulse (or expected one) and the held level.
  initial begin
    logic [2:0] act, want;
    exp_t e;
    forever begin
      @(negedge sys_clk);
      act  = {key_flag, key_release, long_flag};
      want = 3'b000;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL stale_event cyc %0d got none required %b", e.cyc, e.ev);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        want = e.ev;
      end
      if (act != 3'b000 || want != 3'b000) begin
        checks++;
        if (act !== want) begin
          errors++;
          $display("FAIL pulse cyc %0d got %b required %b", cyc, act, want);
        end else begin
          $display("cyc %0d pulse flag/rel/long=%b key_state=%b ok", cyc, act, key_state);
        end
        n_flag += int'(key_flag);
        n_rel  += int'(key_release);
        n_long += int'(long_flag);
      end
      checks++;
      if (key_state !== level) begin
        errors++;
        $display("FAIL key_state cyc %0d got %b required %b", cyc, key_state, level);
      end
    end
  end

  task automatic hold(input logic v, input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #5;
      touch_key = v;
    end
  endtask

  task automatic check_counts(input string name, input int ef, input int er, input int el);
    checks++;
    if (n_flag != ef || n_rel != er || n_long != el) begin
      errors++;
      $display("FAIL %s counts got %0d/%0d/%0d required %0d/%0d/%0d",
               name, n_flag, n_rel, n_long, ef, er, el);
    end else begin
      $display("%s counts flag/rel/long %0d/%0d/%0d ok", name, n_flag, n_rel, n_long);
    end
    n_flag = 0; n_rel = 0; n_long = 0;
  endtask

  task automatic check_state(input string name, input logic want);
    checks++;
    if (key_state !== want) begin
      errors++;
      $display("FAIL %s key_state got %b required %b", name, key_state, want);
    end else begin
      $display("%s key_state=%b ok", name, key_state);
    end
  endtask

  task automatic pulse_reset(input int n);
    @(posedge sys_clk);
    #5;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({key_flag, key_release, long_flag, key_state} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0000",
               {key_flag, key_release, long_flag, key_state});
    end else begin
      $display("reset asserted cyc %0d outputs cleared", cyc);
    end
    repeat (n) @(posedge sys_clk);
    #5;
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic v;
    @(posedge sys_clk);
    #10;
    sys_rst_n = 1'b1;

    hold(1'b1, 10);
    check_counts("idle_high", 0, 0, 0);

    hold(1'b0, 100);
    hold(1'b1, 20);
    check_counts("long_press", 1, 1, 1);

    for (int i = 0; i < 5; i++) begin
      hold(1'b0, 2);
      hold(1'b1, 2);
    end
    hold(1'b1, 10);
    check_counts("bounce", 0, 0, 0);

    hold(1'b0, 15);
    hold(1'b1, 20);
    check_counts("short_press", 1, 1, 0);

    hold(1'b0, 10);
    hold(1'b1, 3);
    hold(1'b0, 4);
    check_state("release_glitch", 1'b1);
    hold(1'b0, 36);
    hold(1'b1, 20);
    check_counts("release_glitch", 1, 1, 1);

    hold(1'b0, 15);
    check_state("before_reset", 1'b1);
    pulse_reset(3);
    hold(1'b0, 30);
    hold(1'b1, 20);
    check_counts("reset_mid_hold", 2, 1, 1);

    v = 1'b0;
    for (int i = 0; i < 40; i++) begin
      hold(v, int'($urandom_range(1, 30)));
      if ($urandom_range(0, 9) == 0) pulse_reset(int'($urandom_range(1, 3)));
      v = ~v;
    end
    hold(1'b1, 20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got %0d required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
